// File: rtl/signal_gen_sequencer.sv
// Run controller for a signal_generator: clears it with a one-cycle sync
// reset, then issues enable strobes every DIV+1 clocks for a programmed
// number of steps (or continuously when the step count is zero).
module signal_gen_sequencer #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned STEP_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [DIV_WIDTH-1:0]  cfg_div_i,
    input  logic [STEP_WIDTH-1:0] cfg_steps_i,
    output logic                  gen_rst_n_o,
    output logic                  gen_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [STEP_WIDTH-1:0] step_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_div_q;
    logic [DIV_WIDTH-1:0]  w_div_nxt;
    logic [DIV_WIDTH-1:0]  r_presc;
    logic [DIV_WIDTH-1:0]  w_presc_nxt;
    logic [STEP_WIDTH-1:0] r_steps_q;
    logic [STEP_WIDTH-1:0] w_steps_nxt;
    logic [STEP_WIDTH-1:0] r_step_cnt;
    logic [STEP_WIDTH-1:0] w_step_nxt;
    logic                  r_gen_rst_n;
    logic                  w_strobe;
    logic                  w_last;

    // Strobe is decoded purely from registered state, no input feeds it
    assign w_strobe = (r_state == S_RUN) && (r_presc == r_div_q);

    // Final strobe of a finite run; zero steps means run until stopped
    assign w_last = (r_steps_q != '0) &&
                    (r_step_cnt == (r_steps_q - STEP_WIDTH'(1)));

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_q;
        w_steps_nxt = r_steps_q;
        w_presc_nxt = r_presc;
        w_step_nxt  = r_step_cnt;
        case (r_state)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    w_div_nxt   = cfg_div_i;
                    w_steps_nxt = cfg_steps_i;
                    w_presc_nxt = '0;
                    w_step_nxt  = '0;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = stop_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (r_presc == r_div_q) begin
                    w_presc_nxt = '0;
                end else begin
                    w_presc_nxt = r_presc + DIV_WIDTH'(1);
                end
                if (w_strobe) begin
                    w_step_nxt = r_step_cnt + STEP_WIDTH'(1);
                end
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_strobe && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; generator reset drops on entry to CLEAR
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_state     <= S_IDLE;
            r_div_q     <= '0;
            r_steps_q   <= '0;
            r_presc     <= '0;
            r_step_cnt  <= '0;
            r_gen_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_q     <= w_div_nxt;
            r_steps_q   <= w_steps_nxt;
            r_presc     <= w_presc_nxt;
            r_step_cnt  <= w_step_nxt;
            r_gen_rst_n <= (w_state_nxt != S_CLEAR);
        end
    end

    assign gen_rst_n_o = r_gen_rst_n;
    assign gen_en_o    = w_strobe;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign step_cnt_o  = r_step_cnt;

endmodule

// File: tb/tb_signal_gen_sequencer.sv
// Scoreboard bench: stimulus pushes expected strobes, done pulses and
// signal probes (keyed by cycle number); a monitor compares at negedge.
module tb_signal_gen_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 16;

    localparam int P_GEN_RST = 0;
    localparam int P_EN      = 1;
    localparam int P_BUSY    = 2;
    localparam int P_DONE    = 3;
    localparam int P_CNT     = 4;
    localparam int P_CNT4    = 5;
    localparam int P_EN4     = 6;
    localparam int P_DONE4   = 7;
    localparam int P_RST4    = 8;
    localparam int P_BUSY4   = 9;

    typedef struct {
        int cyc;
        int cnt;
    } ev_t;

    typedef struct {
        int cyc;
        int sel;
        int expv;
    } pr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [DW-1:0] cfg_div;
    logic [SW-1:0] cfg_steps;
    logic          gen_rst_n;
    logic          gen_en;
    logic          busy;
    logic          done;
    logic [SW-1:0] step_cnt;
    logic          gen_rst_n4;
    logic          gen_en4;
    logic          busy4;
    logic          done4;
    logic [3:0]    step_cnt4;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  en_q[$];
    int   done_q[$];
    pr_t  pr_q[$];

    signal_gen_sequencer #(.DIV_WIDTH(DW), .STEP_WIDTH(SW)) dut (
        .clk_i       (clk),
        .a_rst_n_i   (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .cfg_div_i   (cfg_div),
        .cfg_steps_i (cfg_steps),
        .gen_rst_n_o (gen_rst_n),
        .gen_en_o    (gen_en),
        .busy_o      (busy),
        .done_o      (done),
        .step_cnt_o  (step_cnt)
    );

    // Narrow step counter instance to exercise the continuous-mode wrap
    signal_gen_sequencer #(.DIV_WIDTH(DW), .STEP_WIDTH(4)) dut4 (
        .clk_i       (clk),
        .a_rst_n_i   (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .cfg_div_i   (cfg_div),
        .cfg_steps_i (cfg_steps[3:0]),
        .gen_rst_n_o (gen_rst_n4),
        .gen_en_o    (gen_en4),
        .busy_o      (busy4),
        .done_o      (done4),
        .step_cnt_o  (step_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index, advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sel_val(input int sel);
        case (sel)
            P_GEN_RST: return int'(gen_rst_n);
            P_EN:      return int'(gen_en);
            P_BUSY:    return int'(busy);
            P_DONE:    return int'(done);
            P_CNT:     return int'(step_cnt);
            P_CNT4:    return int'(step_cnt4);
            P_EN4:     return int'(gen_en4);
            P_DONE4:   return int'(done4);
            P_RST4:    return int'(gen_rst_n4);
            P_BUSY4:   return int'(busy4);
            default:   return -1;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            P_GEN_RST: return "gen_rst_n";
            P_EN:      return "gen_en";
            P_BUSY:    return "busy";
            P_DONE:    return "done";
            P_CNT:     return "step_cnt";
            P_CNT4:    return "step_cnt_w4";
            P_EN4:     return "gen_en_w4";
            P_DONE4:   return "done_w4";
            P_RST4:    return "gen_rst_n_w4";
            P_BUSY4:   return "busy_w4";
            default:   return "unknown";
        endcase
    endfunction

    // Monitor: pops scoreboard entries whenever the DUT presents them
    initial begin
        pr_t keep[$];
        forever begin
            @(negedge clk);
            while (en_q.size() > 0 && en_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_strobe cyc=%0d got none, required strobe at cyc %0d", cyc, en_q[0].cyc);
                en_q.delete(0);
            end
            if (gen_en === 1'b1) begin
                n_checks++;
                if (en_q.size() > 0 && en_q[0].cyc == cyc) begin
                    if (int'(step_cnt) != en_q[0].cnt) begin
                        n_fail++;
                        $display("FAIL strobe_cnt cyc=%0d got %0d required %0d", cyc, step_cnt, en_q[0].cnt);
                    end
                    en_q.delete(0);
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_strobe cyc=%0d got gen_en=1 required 0", cyc);
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_done cyc=%0d got none, required done at cyc %0d", cyc, done_q[0]);
                done_q.delete(0);
            end
            if (done === 1'b1) begin
                n_checks++;
                if (done_q.size() > 0 && done_q[0] == cyc) begin
                    done_q.delete(0);
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_done cyc=%0d got done=1 required 0", cyc);
                end
            end
            keep = {};
            foreach (pr_q[i]) begin
                if (pr_q[i].cyc == cyc) begin
                    n_checks++;
                    if (sel_val(pr_q[i].sel) != pr_q[i].expv) begin
                        n_fail++;
                        $display("FAIL probe_%s cyc=%0d got %0d required %0d",
                                 sel_name(pr_q[i].sel), cyc, sel_val(pr_q[i].sel), pr_q[i].expv);
                    end
                end else if (pr_q[i].cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stale_probe_%s cyc=%0d got unchecked required check at cyc %0d",
                             sel_name(pr_q[i].sel), cyc, pr_q[i].cyc);
                end else begin
                    keep.push_back(pr_q[i]);
                end
            end
            pr_q = keep;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_en(input int c, input int cnt);
        ev_t e;
        e.cyc = c;
        e.cnt = cnt;
        en_q.push_back(e);
    endtask

    task automatic exp_done(input int c);
        done_q.push_back(c);
    endtask

    task automatic probe(input int c, input int sel, input int v);
        pr_t p;
        p.cyc  = c;
        p.sel  = sel;
        p.expv = v;
        pr_q.push_back(p);
    endtask

    // One-cycle start pulse; b is the cycle in which start is presented
    task automatic start_run(input int d, input int s, output int b);
        tick();
        cfg_div   = DW'(d);
        cfg_steps = SW'(s);
        start     = 1'b1;
        b         = cyc;
        tick();
        start     = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        int b;
        int b2;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_div   = '0;
        cfg_steps = '0;

        // Reset values
        tick();
        tick();
        b = cyc;
        probe(b, P_GEN_RST, 0);
        probe(b, P_EN, 0);
        probe(b, P_BUSY, 0);
        probe(b, P_DONE, 0);
        probe(b, P_CNT, 0);
        probe(b, P_CNT4, 0);
        tick();
        rst_n = 1'b1;
        b = cyc;
        probe(b, P_GEN_RST, 0);
        probe(b + 1, P_GEN_RST, 1);
        probe(b + 1, P_BUSY, 0);
        tick();

        // Finite run, div=3 steps=4
        start_run(3, 4, b);
        probe(b + 1, P_BUSY, 1);
        probe(b + 1, P_GEN_RST, 0);
        probe(b + 1, P_EN, 0);
        probe(b + 1, P_RST4, 0);
        probe(b + 2, P_GEN_RST, 1);
        for (int j = 1; j <= 4; j++) exp_en(b + 1 + 4 * j, j - 1);
        probe(b + 5, P_EN4, 1);
        exp_done(b + 18);
        probe(b + 18, P_EN, 0);
        probe(b + 18, P_BUSY, 1);
        probe(b + 18, P_DONE4, 1);
        probe(b + 19, P_BUSY, 0);
        probe(b + 19, P_DONE, 0);
        probe(b + 19, P_CNT, 4);
        probe(b + 19, P_CNT4, 4);
        probe(b + 19, P_BUSY4, 0);
        wait_cyc(b + 21);

        // Continuous div=0 for 100 strobes, stop on the last strobe cycle
        start_run(0, 0, b);
        for (int j = 0; j < 100; j++) exp_en(b + 2 + j, j);
        probe(b + 102, P_BUSY, 0);
        probe(b + 102, P_EN, 0);
        probe(b + 102, P_CNT, 100);
        wait_cyc(b + 101);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_cyc(b + 104);

        // Continuous 20 strobes: narrow counter wraps 15 -> 0 and reads 4
        start_run(0, 0, b);
        for (int j = 0; j < 20; j++) exp_en(b + 2 + j, j);
        probe(b + 17, P_CNT4, 15);
        probe(b + 18, P_CNT4, 0);
        probe(b + 22, P_CNT4, 4);
        probe(b + 22, P_CNT, 20);
        probe(b + 22, P_BUSY, 0);
        wait_cyc(b + 21);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_cyc(b + 24);

        // Start with stop in IDLE: stop wins, counter holds
        tick();
        start = 1'b1;
        stop  = 1'b1;
        b = cyc;
        probe(b + 1, P_BUSY, 0);
        probe(b + 1, P_CNT, 20);
        probe(b + 2, P_BUSY, 0);
        probe(b + 2, P_GEN_RST, 1);
        tick();
        start = 1'b0;
        stop  = 1'b0;
        wait_cyc(b + 3);

        // Start during RUN ignored, strobe phase unchanged
        start_run(2, 3, b);
        exp_en(b + 4, 0);
        exp_en(b + 7, 1);
        exp_en(b + 10, 2);
        exp_done(b + 11);
        probe(b + 12, P_BUSY, 0);
        probe(b + 12, P_CNT, 3);
        wait_cyc(b + 5);
        start   = 1'b1;
        cfg_div = DW'(7);
        tick();
        start   = 1'b0;
        wait_cyc(b + 13);

        // cfg_div change mid-run has no effect; next start picks it up
        start_run(1, 3, b);
        exp_en(b + 3, 0);
        exp_en(b + 5, 1);
        exp_en(b + 7, 2);
        exp_done(b + 8);
        wait_cyc(b + 3);
        cfg_div = DW'(5);
        wait_cyc(b + 10);
        start_run(5, 2, b2);
        exp_en(b2 + 7, 0);
        exp_en(b2 + 13, 1);
        exp_done(b2 + 14);
        probe(b2 + 15, P_CNT, 2);
        probe(b2 + 15, P_BUSY, 0);
        wait_cyc(b2 + 16);

        // Async reset during a strobe cycle clears outputs at once
        start_run(1, 0, b);
        exp_en(b + 3, 0);
        exp_en(b + 5, 1);
        exp_en(b + 7, 2);
        probe(b + 9, P_EN, 0);
        probe(b + 9, P_GEN_RST, 0);
        probe(b + 9, P_BUSY, 0);
        probe(b + 9, P_CNT, 0);
        probe(b + 9, P_CNT4, 0);
        probe(b + 10, P_GEN_RST, 0);
        probe(b + 11, P_GEN_RST, 0);
        probe(b + 12, P_GEN_RST, 1);
        probe(b + 12, P_BUSY, 0);
        wait_cyc(b + 9);
        rst_n = 1'b0;
        wait_cyc(b + 11);
        rst_n = 1'b1;
        wait_cyc(b + 14);

        tick();
        tick();
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
